// File: rtl/municao_scheduler_if.sv
// Enemy-fire scheduler bus.
// Groups the game-side inputs and the launch command outputs of municao_scheduler.
//   enable          game running; low freezes scheduling
//   shooter_alive   per-ship fire permission
//   shooter_x/y     packed 11-bit ship positions, ship i at [11i+10:11i]
//   slot_done       per-slot pulse from the projectile datapath: slot free again
//   launch          one-cycle launch command
//   launch_slot     slot index being launched
//   launch_shooter  ship index that fired
//   launch_x/y      projectile start position
//   slot_busy       occupied-slot mask
// master = game/projectile side, slave = scheduler.
interface municao_scheduler_if #(
    parameter int N_SHOOTERS = 4,
    parameter int N_SLOTS    = 4
);
    logic                      enable;
    logic [N_SHOOTERS-1:0]     shooter_alive;
    logic [11*N_SHOOTERS-1:0]  shooter_x;
    logic [11*N_SHOOTERS-1:0]  shooter_y;
    logic [N_SLOTS-1:0]        slot_done;
    logic                      launch;
    logic [1:0]                launch_slot;
    logic [1:0]                launch_shooter;
    logic [10:0]               launch_x;
    logic [10:0]               launch_y;
    logic [N_SLOTS-1:0]        slot_busy;

    modport master (
        output enable, shooter_alive, shooter_x, shooter_y, slot_done,
        input  launch, launch_slot, launch_shooter, launch_x, launch_y, slot_busy
    );

    modport slave (
        input  enable, shooter_alive, shooter_x, shooter_y, slot_done,
        output launch, launch_slot, launch_shooter, launch_x, launch_y, slot_busy
    );
endinterface

// File: rtl/municao_scheduler.sv
// Enemy-fire scheduler: shares a pool of projectile slots among enemy ships.
// A periodic fire tick raises a pending shot; the FSM then picks the next
// eligible ship round-robin plus the lowest free slot and issues a one-cycle
// launch carrying the ship position. Slots return to the pool on slot_done.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    municao_scheduler_if slave (see interface file for signal list)
//
// state   | meaning
// IDLE    | waiting for a pending shot while enabled
// ARB     | choose ship and slot; launch on success, otherwise retry via IDLE
// LAUNCH  | launch pulse is high this cycle
module municao_scheduler #(
    parameter int N_SHOOTERS  = 4,
    parameter int N_SLOTS     = 4,
    parameter int FIRE_PERIOD = 50000000,
    parameter int COOLDOWN    = 100000000
) (
    input  logic                  clk,
    input  logic                  reset,
    municao_scheduler_if.slave    bus
);
    localparam int PCNT_W = 26;
    localparam int CD_W   = 27;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARB    = 2'd1;
    localparam logic [1:0] S_LAUNCH = 2'd2;

    logic [1:0]        state;
    logic [PCNT_W-1:0] pcnt;
    logic              pending;
    logic [1:0]        rr;
    logic [CD_W-1:0]   cd [N_SHOOTERS];

    logic               tick;
    logic               ship_ok;
    logic [1:0]         ship_sel;
    logic               slot_ok;
    logic [1:0]         slot_sel;
    logic [N_SLOTS-1:0] slot_onehot;
    logic               arb_go;
    int                 idx;

    assign tick = (pcnt == PCNT_W'(FIRE_PERIOD - 1));

    // First eligible ship in rr, rr+1, ... order (mod N_SHOOTERS).
    always_comb begin
        ship_ok  = 1'b0;
        ship_sel = 2'd0;
        idx      = 0;
        for (int k = 0; k < N_SHOOTERS; k++) begin
            idx = int'(rr) + k;
            if (idx >= N_SHOOTERS) idx = idx - N_SHOOTERS;
            if (!ship_ok && bus.shooter_alive[idx] && (cd[idx] == '0)) begin
                ship_ok  = 1'b1;
                ship_sel = 2'(idx);
            end
        end
    end

    // Lowest free slot; registered busy mask only, so a slot freed this
    // cycle becomes allocatable on the next one.
    always_comb begin
        slot_ok     = 1'b0;
        slot_sel    = 2'd0;
        slot_onehot = '0;
        for (int j = 0; j < N_SLOTS; j++) begin
            if (!slot_ok && !bus.slot_busy[j]) begin
                slot_ok        = 1'b1;
                slot_sel       = 2'(j);
                slot_onehot[j] = 1'b1;
            end
        end
    end

    assign arb_go = (state == S_ARB) && bus.enable && ship_ok && slot_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= S_IDLE;
            pcnt               <= '0;
            pending            <= 1'b0;
            rr                 <= 2'd0;
            for (int i = 0; i < N_SHOOTERS; i++) cd[i] <= '0;
            bus.launch         <= 1'b0;
            bus.launch_slot    <= 2'd0;
            bus.launch_shooter <= 2'd0;
            bus.launch_x       <= '0;
            bus.launch_y       <= '0;
            bus.slot_busy      <= '0;
        end else begin
            bus.launch <= 1'b0;

            if (bus.enable) begin
                pcnt <= tick ? '0 : pcnt + PCNT_W'(1);
            end

            // A tick coinciding with a held shot is absorbed, not queued.
            if (!bus.enable || arb_go) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end

            for (int i = 0; i < N_SHOOTERS; i++) begin
                if (arb_go && (ship_sel == 2'(i))) begin
                    cd[i] <= CD_W'(COOLDOWN);
                end else if (cd[i] != '0) begin
                    cd[i] <= cd[i] - CD_W'(1);
                end
            end

            bus.slot_busy <= (bus.slot_busy & ~bus.slot_done) | (arb_go ? slot_onehot : '0);

            if (arb_go) begin
                bus.launch         <= 1'b1;
                bus.launch_slot    <= slot_sel;
                bus.launch_shooter <= ship_sel;
                bus.launch_x       <= bus.shooter_x[int'(ship_sel)*11 +: 11];
                bus.launch_y       <= bus.shooter_y[int'(ship_sel)*11 +: 11];
                rr                 <= (ship_sel == 2'(N_SHOOTERS - 1)) ? 2'd0 : ship_sel + 2'd1;
            end

            case (state)
                S_IDLE:   if (bus.enable && pending) state <= S_ARB;
                S_ARB:    state <= arb_go ? S_LAUNCH : S_IDLE;
                S_LAUNCH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_municao_scheduler.sv
module tb_municao_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   c0 = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    municao_scheduler_if #(.N_SHOOTERS(4), .N_SLOTS(4)) bus();

    municao_scheduler #(
        .N_SHOOTERS(4), .N_SLOTS(4), .FIRE_PERIOD(8), .COOLDOWN(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Reset, release on a falling edge; c0 marks edge 0 so that the k-th
    // rising edge after release is observed at the falling edge with cyc-c0 == k.
    task automatic start_run();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_launch(input int max_cycles, output int at);
        at = -1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (bus.launch === 1'b1) begin
                at = cyc - c0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.launch !== 1'b0) begin errors++; $display("FAIL reset_launch got %b want 0", bus.launch); end
        checks++; if (bus.slot_busy !== 4'h0) begin errors++; $display("FAIL reset_busy got %h want 0", bus.slot_busy); end
        checks++; if (bus.launch_x !== 11'd0 || bus.launch_y !== 11'd0) begin errors++; $display("FAIL reset_xy got %0d/%0d want 0/0", bus.launch_x, bus.launch_y); end
        checks++; if (bus.launch_slot !== 2'd0 || bus.launch_shooter !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d/%0d want 0/0", bus.launch_slot, bus.launch_shooter); end
    endtask

    task automatic test_round_robin();
        int at;
        start_run();
        for (int k = 0; k < 4; k++) begin
            wait_launch(20, at);
            checks++; if (at !== 10 + 8*k) begin errors++; $display("FAIL rr_time%0d got %0d want %0d", k, at, 10 + 8*k); end
            checks++; if (bus.launch_shooter !== 2'(k)) begin errors++; $display("FAIL rr_ship%0d got %0d want %0d", k, bus.launch_shooter, k); end
            checks++; if (bus.launch_slot !== 2'(k)) begin errors++; $display("FAIL rr_slot%0d got %0d want %0d", k, bus.launch_slot, k); end
            checks++; if (bus.launch_x !== 11'(100 + k) || bus.launch_y !== 11'd50) begin errors++; $display("FAIL rr_xy%0d got %0d/%0d want %0d/50", k, bus.launch_x, bus.launch_y, 100 + k); end
            @(negedge clk);
            checks++; if (bus.launch !== 1'b0) begin errors++; $display("FAIL rr_pulse%0d got %b want 0", k, bus.launch); end
        end
        checks++; if (bus.slot_busy !== 4'hF) begin errors++; $display("FAIL rr_busy got %h want f", bus.slot_busy); end
    endtask

    task automatic test_pool_exhaustion();
        int seen = 0;
        int at;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.launch === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL pool_nolaunch got %0d want 0", seen); end
        checks++; if (dut.pending !== 1'b1) begin errors++; $display("FAIL pool_pending got %b want 1", dut.pending); end
        bus.slot_done = 4'b0100;
        @(negedge clk);
        bus.slot_done = 4'b0000;
        checks++; if (bus.slot_busy !== 4'b1011) begin errors++; $display("FAIL pool_freed got %h want b", bus.slot_busy); end
        wait_launch(3, at);
        checks++; if (at !== 68) begin errors++; $display("FAIL pool_time got %0d want 68", at); end
        checks++; if (bus.launch_slot !== 2'd2 || bus.launch_shooter !== 2'd0) begin errors++; $display("FAIL pool_alloc got slot %0d ship %0d want 2/0", bus.launch_slot, bus.launch_shooter); end
    endtask

    task automatic test_cooldown_alive();
        int at;
        bus.shooter_alive = 4'b0010;
        start_run();
        wait_launch(20, at);
        checks++; if (at !== 10 || bus.launch_shooter !== 2'd1 || bus.launch_slot !== 2'd0) begin errors++; $display("FAIL cd_first got t%0d ship %0d slot %0d want t10 1 0", at, bus.launch_shooter, bus.launch_slot); end
        checks++; if (bus.launch_x !== 11'd101) begin errors++; $display("FAIL cd_x got %0d want 101", bus.launch_x); end
        wait_launch(40, at);
        checks++; if (at !== 32 || bus.launch_shooter !== 2'd1 || bus.launch_slot !== 2'd1) begin errors++; $display("FAIL cd_second got t%0d ship %0d slot %0d want t32 1 1", at, bus.launch_shooter, bus.launch_slot); end
        wait_launch(40, at);
        checks++; if (at !== 54 || bus.launch_shooter !== 2'd1 || bus.launch_slot !== 2'd2) begin errors++; $display("FAIL cd_third got t%0d ship %0d slot %0d want t54 1 2", at, bus.launch_shooter, bus.launch_slot); end
        bus.shooter_alive = 4'hF;
    endtask

    task automatic test_enable_gating();
        int at;
        int seen = 0;
        start_run();
        wait_launch(20, at);
        checks++; if (at !== 10 || bus.launch_slot !== 2'd0) begin errors++; $display("FAIL en_first got t%0d slot %0d want t10 0", at, bus.launch_slot); end
        repeat (3) @(negedge clk);
        bus.enable = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) bus.slot_done = 4'b0001;
            if (i == 6) bus.slot_done = 4'b0000;
            @(negedge clk);
            if (bus.launch === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL en_nolaunch got %0d want 0", seen); end
        checks++; if (dut.pcnt !== 26'd5) begin errors++; $display("FAIL en_pcnt got %0d want 5", dut.pcnt); end
        checks++; if (bus.slot_busy !== 4'h0) begin errors++; $display("FAIL en_done got %h want 0", bus.slot_busy); end
        bus.enable = 1'b1;
        wait_launch(20, at);
        checks++; if (at !== 58 || bus.launch_shooter !== 2'd1 || bus.launch_slot !== 2'd0) begin errors++; $display("FAIL en_resume got t%0d ship %0d slot %0d want t58 1 0", at, bus.launch_shooter, bus.launch_slot); end
    endtask

    task automatic test_async_reset();
        int at;
        start_run();
        wait_launch(20, at);
        wait_launch(20, at);
        checks++; if (at !== 18 || bus.launch_shooter !== 2'd1) begin errors++; $display("FAIL ar_pre got t%0d ship %0d want t18 1", at, bus.launch_shooter); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.launch !== 1'b0 || bus.slot_busy !== 4'h0) begin errors++; $display("FAIL ar_clear got launch %b busy %h want 0 0", bus.launch, bus.slot_busy); end
        @(negedge clk);
        reset = 1'b0;
        c0 = cyc;
        wait_launch(20, at);
        checks++; if (at !== 10 || bus.launch_shooter !== 2'd0 || bus.launch_slot !== 2'd0) begin errors++; $display("FAIL ar_post got t%0d ship %0d slot %0d want t10 0 0", at, bus.launch_shooter, bus.launch_slot); end
    endtask

    task automatic test_simultaneous();
        int at;
        start_run();
        wait_launch(20, at);
        checks++; if (at !== 10 || bus.launch_slot !== 2'd0) begin errors++; $display("FAIL sim_first got t%0d slot %0d want t10 0", at, bus.launch_slot); end
        repeat (7) @(negedge clk);
        bus.slot_done = 4'b0001;
        @(negedge clk);
        bus.slot_done = 4'b0000;
        checks++; if (bus.launch !== 1'b1 || bus.launch_slot !== 2'd1 || bus.launch_shooter !== 2'd1) begin errors++; $display("FAIL sim_alloc got launch %b slot %0d ship %0d want 1 1 1", bus.launch, bus.launch_slot, bus.launch_shooter); end
        checks++; if (bus.slot_busy !== 4'b0010) begin errors++; $display("FAIL sim_busy got %h want 2", bus.slot_busy); end
    endtask

    initial begin
        bus.enable        = 1'b1;
        bus.shooter_alive = 4'hF;
        bus.shooter_x     = {11'd103, 11'd102, 11'd101, 11'd100};
        bus.shooter_y     = {11'd50, 11'd50, 11'd50, 11'd50};
        bus.slot_done     = 4'h0;
        test_reset();
        test_round_robin();
        test_pool_exhaustion();
        test_cooldown_alive();
        test_enable_gating();
        test_async_reset();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
